// File: rtl/clksel_sequencer.sv
// clksel_sequencer: drives hsclk_sel of the CPU clock switch, waiting for the switch handshake and enforcing a dwell time.
// Define CLKSEL_TIMEOUT_EN to add a switch-completion timeout with a sticky switch_err flag.
module clksel_sequencer #(
  parameter int SYNC_STAGES = 2,
  parameter int MIN_DWELL   = 4,
  parameter int TIMEOUT_CYC = 255,
  parameter int CNT_W       = 8
) (
  input  logic hsclk_in,
  input  logic rst_b,
  input  logic slow_req,
  input  logic turbo_en,
  input  logic hsclk_selected,
  input  logic lsclk_selected,
  output logic hsclk_sel,
  output logic busy,
  output logic fast_active,
  output logic switch_err
);
  typedef enum logic [1:0] {SLOW, TO_FAST, FAST, TO_SLOW} state_t;
  state_t r_state, w_next;
  logic [SYNC_STAGES-1:0] r_hs_sync, r_ls_sync;
  logic [CNT_W-1:0] r_dwell;
  logic r_sel, r_err, w_sel, w_err, w_hs_s, w_ls_s, w_dwell_done, w_to_hit;
  assign w_hs_s       = r_hs_sync[SYNC_STAGES-1];
  assign w_ls_s       = r_ls_sync[SYNC_STAGES-1];
  assign w_dwell_done = r_dwell == CNT_W'(MIN_DWELL);
`ifdef CLKSEL_TIMEOUT_EN
  logic [CNT_W-1:0] r_to;
  // Counts only while a switch is in flight; any state change restarts it.
  always_ff @(posedge hsclk_in or negedge rst_b)
    if (!rst_b) r_to <= '0;
    else r_to <= (w_next != r_state || !busy) ? '0 : r_to + 1'b1;
  assign w_to_hit = r_to == CNT_W'(TIMEOUT_CYC - 1);
`else
  logic w_unused_timeout;
  assign w_unused_timeout = TIMEOUT_CYC == 0;
  assign w_to_hit = 1'b0;
`endif
  // Handshake completion is tested before the timeout so it wins a tie.
  always_comb begin
    w_next = r_state;
    w_sel  = r_sel;
    w_err  = r_err;
    case (r_state)
      SLOW:
        if (turbo_en && !slow_req && w_dwell_done && !r_err) begin
          w_next = TO_FAST;
          w_sel  = 1'b1;
        end
      TO_FAST:
        if (w_hs_s && !w_ls_s) w_next = FAST;
        else if (w_to_hit) begin
          w_next = SLOW;
          w_sel  = 1'b0;
          w_err  = 1'b1;
        end
      FAST:
        if ((slow_req || !turbo_en) && w_dwell_done) begin
          w_next = TO_SLOW;
          w_sel  = 1'b0;
        end
      TO_SLOW:
        if (w_ls_s && !w_hs_s) w_next = SLOW;
        else if (w_to_hit) begin
          w_next = SLOW;
          w_err  = 1'b1;
        end
      default: w_next = SLOW;
    endcase
  end
  always_ff @(posedge hsclk_in or negedge rst_b)
    if (!rst_b) begin
      r_state   <= SLOW;
      r_sel     <= 1'b0;
      r_err     <= 1'b0;
      r_dwell   <= '0;
      r_hs_sync <= '0;
      r_ls_sync <= '0;
    end else begin
      r_state   <= w_next;
      r_sel     <= w_sel;
      r_err     <= w_err;
      r_dwell   <= (w_next != r_state) ? '0 : r_dwell + CNT_W'(!w_dwell_done);
      r_hs_sync <= {r_hs_sync[SYNC_STAGES-2:0], hsclk_selected};
      r_ls_sync <= {r_ls_sync[SYNC_STAGES-2:0], lsclk_selected};
    end
  assign hsclk_sel   = r_sel;
  assign busy        = (r_state == TO_FAST) || (r_state == TO_SLOW);
  assign fast_active = r_state == FAST;
  assign switch_err  = r_err;
endmodule

// File: tb/tb_clksel_sequencer.sv
// tb_clksel_sequencer: directed scenarios plus a randomized clock-switch partner, all checked against a mode-level model.
module tb_clksel_sequencer;
  localparam int SYNC = 2, DWELL = 4, TO = 16;
  logic clk = 1'b0, rst_b = 1'b0, slow_req = 1'b0, turbo_en = 1'b0, hs_in = 1'b0, ls_in = 1'b0;
  logic hsclk_sel, busy, fast_active, switch_err;
  int n_tests = 0, n_fail = 0;
  bit m_sel, m_busy, m_err;
  int m_since, m_wait;
  bit hq[$], lq[$];
  always #5 clk = ~clk;
  clksel_sequencer #(.SYNC_STAGES(SYNC), .MIN_DWELL(DWELL), .TIMEOUT_CYC(TO), .CNT_W(8)) dut (
    .hsclk_in(clk), .rst_b(rst_b), .slow_req(slow_req), .turbo_en(turbo_en),
    .hsclk_selected(hs_in), .lsclk_selected(ls_in),
    .hsclk_sel(hsclk_sel), .busy(busy), .fast_active(fast_active), .switch_err(switch_err));
  task automatic check(string tag, logic got, logic exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %b expected %b", tag, $time, got, exp);
    end
  endtask
  task automatic model_reset();
    m_sel = 0; m_busy = 0; m_err = 0; m_since = 0; m_wait = 0;
    hq.delete(); lq.delete();
    repeat (SYNC) begin hq.push_back(1'b0); lq.push_back(1'b0); end
  endtask
  // Model: the CPU is either settled on a clock (sel) or waiting for the switch to confirm it.
  task automatic model_step();
    bit hs_s, ls_s, done, arrived;
    if (!rst_b) begin model_reset(); return; end
    hs_s = hq.pop_front(); ls_s = lq.pop_front();
    hq.push_back(hs_in); lq.push_back(ls_in);
    done = m_since >= DWELL;
    arrived = m_sel ? (hs_s && !ls_s) : (ls_s && !hs_s);
    if (!m_busy) begin
      if (!m_sel && turbo_en && !slow_req && !m_err && done) begin m_sel = 1; m_busy = 1; m_wait = 0; end
      else if (m_sel && (slow_req || !turbo_en) && done) begin m_sel = 0; m_busy = 1; m_wait = 0; end
      else m_since++;
    end else if (arrived) begin m_busy = 0; m_since = 0; end
`ifdef CLKSEL_TIMEOUT_EN
    else if (m_wait == TO - 1) begin m_busy = 0; m_sel = 0; m_err = 1; m_since = 0; end
`endif
    else m_wait++;
  endtask
  task automatic tick(int n);
    repeat (n) begin
      @(posedge clk);
      model_step();
      #1;
      check("sel", hsclk_sel, m_sel);
      check("busy", busy, m_busy);
      check("fast", fast_active, m_sel && !m_busy);
      check("err", switch_err, m_err);
    end
  endtask
  initial begin
    bit ever, cur;
    int gap;
    model_reset();
    // 1: release reset requesting fast
    turbo_en = 1; ls_in = 1; hs_in = 0;
    tick(2);
    check("rst_sel", hsclk_sel, 0); check("rst_busy", busy, 0);
    rst_b = 1;
    tick(4); check("t1_sel_dwell", hsclk_sel, 0);
    tick(1); check("t1_sel", hsclk_sel, 1); check("t1_busy", busy, 1);
    hs_in = 1; ls_in = 0;
    tick(2); check("t1_fast_early", fast_active, 0);
    tick(1); check("t1_fast", fast_active, 1); check("t1_busy_done", busy, 0);
    // 3b/2: slow request on the first FAST cycle honours dwell, then handover stalls
    slow_req = 1;
    tick(4); check("t3_sel_dwell", hsclk_sel, 1);
    tick(1); check("t2_sel", hsclk_sel, 0); check("t2_busy", busy, 1);
    slow_req = 0; hs_in = 0; ls_in = 0;
    tick(10); check("t2_stall_busy", busy, 1); check("t2_stall_sel", hsclk_sel, 0);
    ls_in = 1;
    tick(3); check("t2_slow_busy", busy, 0); check("t2_slow_fast", fast_active, 0);
    // 3a: slow_req pulse during TO_FAST is ignored
    hs_in = 0; ls_in = 0;
    tick(5); check("t3_busy", busy, 1); check("t3_sel", hsclk_sel, 1);
    slow_req = 1; tick(1); slow_req = 0;
    hs_in = 1;
    tick(3); check("t3_fast", fast_active, 1); check("t3_sel_hold", hsclk_sel, 1);
    // 4: dropping turbo_en leaves FAST after dwell, then stays slow
    turbo_en = 0;
    tick(4); check("t4_sel_dwell", hsclk_sel, 1);
    tick(1); check("t4_sel", hsclk_sel, 0); check("t4_busy", busy, 1);
    hs_in = 0; ls_in = 1;
    tick(3); check("t4_slow", busy, 0);
    ever = 0;
    repeat (100) begin tick(1); ever |= hsclk_sel; end
    check("t4_idle_sel", ever, 0);
    // 5: asynchronous reset in TO_FAST
    turbo_en = 1;
    tick(1); check("t5_busy", busy, 1);
    #2 rst_b = 0; model_reset();
    #1 check("t5_async_sel", hsclk_sel, 0); check("t5_async_busy", busy, 0);
    check("t5_async_fast", fast_active, 0); check("t5_async_err", switch_err, 0);
    tick(2); rst_b = 1;
    tick(4); check("t5_sel_dwell", hsclk_sel, 0);
    tick(1); check("t5_sel", hsclk_sel, 1);
    hs_in = 1; ls_in = 0;
    tick(3); check("t5_fast", fast_active, 1);
    // 6: switch never answers
    rst_b = 0; model_reset(); tick(1);
    hs_in = 0; ls_in = 0; rst_b = 1;
    tick(5); check("t6_busy", busy, 1);
    tick(TO - 1); check("t6_busy_wait", busy, 1); check("t6_err_wait", switch_err, 0);
    tick(1);
`ifdef CLKSEL_TIMEOUT_EN
    check("t6_to_busy", busy, 0); check("t6_to_sel", hsclk_sel, 0); check("t6_to_err", switch_err, 1);
    ls_in = 1;
    tick(20); check("t6_blocked_sel", hsclk_sel, 0); check("t6_sticky_err", switch_err, 1);
`else
    tick(20); check("t6_hang_busy", busy, 1); check("t6_hang_sel", hsclk_sel, 1); check("t6_no_err", switch_err, 0);
`endif
    // Random phase: bench acts as the clock switch with random handover length and glitch pattern
    rst_b = 0; model_reset(); tick(1);
    hs_in = 0; ls_in = 1; rst_b = 1; cur = 0; gap = 0;
    repeat (4000) begin
      if ($urandom_range(0, 599) == 0) begin rst_b = 0; model_reset(); tick(1); rst_b = 1; end
      if ($urandom_range(0, 7) == 0) turbo_en = ~turbo_en;
      if ($urandom_range(0, 9) == 0) slow_req = ~slow_req;
      if (gap == 0 && hsclk_sel != cur) gap = $urandom_range(1, 20);
      if (gap > 0) begin
        gap--;
        if (gap == 0) begin cur = hsclk_sel; hs_in = cur; ls_in = !cur; end
        else begin hs_in = 1'($urandom_range(0, 1)); ls_in = hs_in; end
      end
      tick(1);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
